// File: rtl/mop_arbiter.sv
// Two-requester arbiter for a shared operational unit: round-robin tie break,
// done-based release, per-grant watchdog and a one-cycle dead gap between owners.
module mop_arbiter #(
    parameter int unsigned MW     = 9,
    parameter int unsigned MAXCYC = 255
) (
    input  logic          clk,
    input  logic          res,
    input  logic          req0,
    input  logic          req1,
    input  logic          done0,
    input  logic          done1,
    input  logic [MW-1:0] mop0,
    input  logic [MW-1:0] mop1,
    input  logic          xin,
    input  logic          yin,
    output logic [MW-1:0] mop,
    output logic          gnt0,
    output logic          gnt1,
    output logic          x0,
    output logic          y0,
    output logic          x1,
    output logic          y1,
    output logic          busy,
    output logic          err
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LIMIT = CW'(MAXCYC - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    state_t        state, state_n;
    logic          last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_n;

    // Next-state: done wins over watchdog expiry; last-owner flips the tie break.
    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (req0 && (!req1 || last)) begin
                    state_n = OWN0;
                end else if (req1) begin
                    state_n = OWN1;
                end
            end
            OWN0: begin
                if (done0) begin
                    state_n = GAP;
                    last_n  = 1'b0;
                end else if (cnt == LIMIT) begin
                    state_n = GAP;
                    last_n  = 1'b0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            OWN1: begin
                if (done1) begin
                    state_n = GAP;
                    last_n  = 1'b1;
                end else if (cnt == LIMIT) begin
                    state_n = GAP;
                    last_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
            gnt0  <= (state_n == OWN0);
            gnt1  <= (state_n == OWN1);
            busy  <= (state_n == OWN0) || (state_n == OWN1);
            err   <= err_n;
        end
    end

    // Datapath routing follows the owner; the non-owner and dead cycles see zeros.
    always_comb begin
        mop = '0;
        x0  = 1'b0;
        y0  = 1'b0;
        x1  = 1'b0;
        y1  = 1'b0;
        if (state == OWN0) begin
            mop = mop0;
            x0  = xin;
            y0  = yin;
        end else if (state == OWN1) begin
            mop = mop1;
            x1  = xin;
            y1  = yin;
        end
    end

endmodule

// File: tb/tb_mop_arbiter.sv
// Self-checking bench for mop_arbiter: owner-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mop_arbiter;

    localparam int MW  = 9;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          req0, req1, done0, done1, xin, yin;
    logic [MW-1:0] mop0, mop1, mop;
    logic          gnt0, gnt1, x0, y0, x1, y1, busy, err;

    int total = 0;
    int bad   = 0;

    mop_arbiter #(.MW(MW), .MAXCYC(MAX)) dut (
        .clk(clk), .res(res), .req0(req0), .req1(req1), .done0(done0), .done1(done1),
        .mop0(mop0), .mop1(mop1), .xin(xin), .yin(yin), .mop(mop),
        .gnt0(gnt0), .gnt1(gnt1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the unit, how long, and whether a dead cycle follows.
    int m_owner = -1;   // -1 none, else requester index
    int m_held  = 0;    // completed cycles of current grant
    bit m_gap   = 0;
    bit m_err   = 0;
    int m_last  = 1;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_gap = 0; m_err = 0; m_last = 1;
    endtask

    always @(negedge res) model_reset();

    always @(posedge clk) begin
        if (!res) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 0;
            m_err = 0;
        end else if (m_owner < 0) begin
            m_err  = 0;
            m_held = 0;
            if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
        end else begin
            bit d;
            d = (m_owner == 0) ? done0 : done1;
            if (d || m_held + 1 >= MAX) begin
                m_err   = !d;
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic [MW-1:0] emop;
        emop = (m_owner == 0) ? mop0 : (m_owner == 1) ? mop1 : '0;
        check("gnt0", 32'(gnt0), 32'(m_owner == 0));
        check("gnt1", 32'(gnt1), 32'(m_owner == 1));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("err",  32'(err),  32'(m_err));
        check("mop",  32'(mop),  32'(emop));
        check("xy",   32'({x0, y0, x1, y1}),
              32'({(m_owner == 0) & xin, (m_owner == 0) & yin,
                   (m_owner == 1) & xin, (m_owner == 1) & yin}));
        check("overlap", 32'(gnt0 & gnt1), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        res = 1'b0; req0 = 0; req1 = 0; done0 = 0; done1 = 0;
        xin = 0; yin = 0; mop0 = '0; mop1 = '0;
        step(2);
        check("rst_outs", 32'({gnt0, gnt1, busy, err, x0, y0, x1, y1}), 32'd0);
        check("rst_mop", 32'(mop), 32'd0);
        res = 1'b1;
        step(1);

        // Tie after reset goes to requester 0.
        req0 = 1; req1 = 1; mop0 = 9'h0A5; mop1 = 9'h15A;
        step(1);
        check("tie0_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("tie0_mop", 32'(mop), 32'h0A5);

        // Release by done0: GAP, IDLE, then requester 1.
        done0 = 1;
        step(1);
        done0 = 0;
        check("gap_mop", 32'(mop), 32'd0);
        check("gap_gnt", 32'({gnt0, gnt1, busy, err}), 32'd0);
        step(1);
        check("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        step(1);
        check("rr_gnt1", 32'({gnt0, gnt1}), 32'b01);
        check("rr_mop1", 32'(mop), 32'h15A);
        done1 = 1;
        step(1);
        done1 = 0;
        step(2);
        check("rr_gnt0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0; req1 = 0; done0 = 1;
        step(1);
        done0 = 0;
        step(2);

        // Watchdog: requester 1 never signals done.
        req1 = 1;
        step(1);
        n = 0;
        while (gnt1 && n < 20) begin
            n++;
            step(1);
        end
        check("wd_len", 32'(n), 32'd4);
        check("wd_err", 32'(err), 32'd1);
        req1 = 0;
        step(1);
        check("wd_err_clr", 32'({err, busy}), 32'd0);

        // done on the last allowed cycle releases cleanly.
        req1 = 1;
        step(4);
        done1 = 1;
        step(1);
        check("wd_done_err", 32'({err, gnt1}), 32'd0);
        done1 = 0; req1 = 0;
        step(2);

        // Condition routing and ignored request drop.
        req0 = 1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            xin = i[0]; yin = i[1];
            #1;
            check("route", 32'({x0, y0, x1, y1}), 32'({i[0], i[1], 2'b00}));
        end
        req0 = 0;
        step(2);
        check("hold_gnt0", 32'(gnt0), 32'd1);
        done0 = 1;
        step(1);
        done0 = 0;
        step(2);

        // Async reset mid-grant, then tie resolves to requester 0 again.
        req1 = 1; mop1 = 9'h1FF;
        step(2);
        check("own1_pre", 32'(gnt1), 32'd1);
        #2 res = 1'b0;
        #1;
        check("arst", 32'({gnt1, busy, err}), 32'd0);
        check("arst_mop", 32'(mop), 32'd0);
        step(1);
        res = 1'b1; req0 = 1; req1 = 1;
        step(1);
        check("arst_tie", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0; req1 = 0;

        // Randomized traffic with rare done, so the watchdog fires often.
        repeat (3000) begin
            @(posedge clk);
            #1;
            req0  = ($urandom_range(3) != 0);
            req1  = ($urandom_range(3) != 0);
            done0 = ($urandom_range(7) == 0);
            done1 = ($urandom_range(7) == 0);
            mop0  = MW'($urandom);
            mop1  = MW'($urandom);
            xin   = $urandom_range(1);
            yin   = $urandom_range(1);
            res   = ($urandom_range(199) != 0);
        end
        res = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
